// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC cosine arbiter and its iteration core.
// Angles and results are signed fixed point with 20 fractional bits.
package cordic_pkg;

  localparam int W_DEFAULT     = 22;
  localparam int ANGLE_MAX_PI2 = 32'h0019_21FB;
  localparam int ONE_Q20       = 32'h0010_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_BUSY,
    S_DELIVER
  } arb_state_e;

endpackage

// File: rtl/cordic_unrolled_four_loop.sv
// 16-iteration rotation-mode CORDIC cosine, four iterations per clock.
// One clk_en pulse starts a job; done pulses once with cos_out valid.
module cordic_unrolled_four_loop
  import cordic_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         clk_en,
  input  logic         reset,
  input  logic [W-1:0] angle,
  output logic [W-1:0] cos_out,
  output logic         done
);

  localparam int GUARD = 4;
  localparam int IW    = W + GUARD;
  localparam int FRAC  = 20;
  // 1/gain of 16 CORDIC micro-rotations, in Q(FRAC+GUARD)
  localparam logic signed [IW-1:0] K_QG   = IW'(10188014);
  localparam logic signed [IW-1:0] ONE_IW = IW'(ONE_Q20);
  localparam logic [2:0] PH_IDLE = 3'd0;
  localparam logic [2:0] PH_OUT  = 3'd5;

  logic [2:0]              phase_q, phase_d;
  logic                    vld_p1;
  logic signed [IW-1:0]    x_p0, y_p0, x_n, y_n, xt;
  logic signed [W-1:0]     z_p0, z_n;
  logic signed [IW+W-1:0]  prod;
  logic signed [IW-1:0]    fin;
  logic signed [W-1:0]     cos_p1;
  logic [1:0]              blk;
  int                      base;

  function automatic int atan_q20(input int i);
    case (i)
      0:  return 823550;
      1:  return 486170;
      2:  return 256879;
      3:  return 130396;
      4:  return 65451;
      5:  return 32757;
      6:  return 16383;
      7:  return 8192;
      8:  return 4096;
      9:  return 2048;
      10: return 1024;
      11: return 512;
      12: return 256;
      13: return 128;
      14: return 64;
      15: return 32;
      default: return 0;
    endcase
  endfunction

  function automatic logic signed [W-1:0] rnd_sat(input logic signed [IW-1:0] v);
    logic signed [IW-1:0] r;
    r = (v + IW'(1 <<< (GUARD - 1))) >>> GUARD;
    if (r > ONE_IW) return W'(ONE_IW);
    if (r < -ONE_IW) return W'(-ONE_IW);
    return r[W-1:0];
  endfunction

  always_comb begin
    phase_d = phase_q;
    if (clk_en) phase_d = 3'd1;
    else if (phase_q == PH_OUT) phase_d = PH_IDLE;
    else if (phase_q != PH_IDLE) phase_d = phase_q + 3'd1;
  end

  always_comb begin
    x_n  = x_p0;
    y_n  = y_p0;
    z_n  = z_p0;
    xt   = x_p0;
    blk  = phase_q[1:0] - 2'd1;
    base = 4 * int'(blk);
    for (int j = 0; j < 4; j++) begin
      xt = x_n;
      if (!z_n[W-1]) begin
        x_n = x_n - (y_n >>> (base + j));
        y_n = y_n + (xt >>> (base + j));
        z_n = z_n - W'(atan_q20(base + j));
      end else begin
        x_n = x_n + (y_n >>> (base + j));
        y_n = y_n - (xt >>> (base + j));
        z_n = z_n + W'(atan_q20(base + j));
      end
    end
  end

  // Residual angle left after 16 steps is folded back in: cos(a) ~ x - y*z
  always_comb begin
    prod = y_p0 * z_p0;
    fin  = x_p0 - IW'(prod >>> FRAC);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= PH_IDLE;
      vld_p1  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      vld_p1  <= (phase_q == PH_OUT) && !clk_en;
    end
  end

  // Stage p0: iteration state, four micro-rotations per cycle
  always_ff @(posedge clk) begin
    if (clk_en) begin
      x_p0 <= K_QG;
      y_p0 <= '0;
      z_p0 <= angle;
    end else if (phase_q != PH_IDLE && phase_q != PH_OUT) begin
      x_p0 <= x_n;
      y_p0 <= y_n;
      z_p0 <= z_n;
    end
  end

  // Stage p1: rounded, saturated result
  always_ff @(posedge clk) begin
    if (phase_q == PH_OUT) cos_p1 <= rnd_sat(fin);
  end

  assign cos_out = cos_p1;
  assign done    = vld_p1;

endmodule

// File: rtl/cordic_cos_arbiter.sv
// Round-robin arbiter sharing one CORDIC cosine core among N_REQ requesters,
// with range checking of the angle and a BUSY timeout.
module cordic_cos_arbiter
  import cordic_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int W       = W_DEFAULT,
  parameter int TIMEOUT = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_angle,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_cos,
  output logic               rsp_err,
  output logic               busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_e          state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    tag_q, tag_d;
  logic [W-1:0]        angle_q, angle_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [W-1:0]        rsp_cos_q, rsp_cos_d;
  logic                rsp_err_q, rsp_err_d;

  logic [W-1:0]        ang_arr [N_REQ];
  logic [PTR_W-1:0]    cand, gnt_idx;
  logic                gnt_any;
  logic [W-1:0]        sel_angle;
  logic                in_range;
  logic                core_en;
  logic                core_done;
  logic [W-1:0]        core_cos;

  always_comb begin
    for (int k = 0; k < N_REQ; k++) ang_arr[k] = req_angle[k*W +: W];
  end

  // First valid requester at or after rr_ptr, wrapping
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int o = 0; o < N_REQ; o++) begin
      cand = PTR_W'((int'(rr_ptr_q) + o) % N_REQ);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    sel_angle = ang_arr[gnt_idx];
    in_range  = !sel_angle[W-1] && (sel_angle <= W'(ANGLE_MAX_PI2));
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    tag_d     = tag_q;
    angle_d   = angle_q;
    cnt_d     = cnt_q;
    rsp_cos_d = rsp_cos_q;
    rsp_err_d = rsp_err_q;
    req_ready = '0;
    rsp_valid = '0;
    core_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          req_ready[gnt_idx] = 1'b1;
          tag_d   = gnt_idx;
          angle_d = sel_angle;
          if (in_range) begin
            state_d = S_LAUNCH;
          end else begin
            state_d   = S_DELIVER;
            rsp_cos_d = '0;
            rsp_err_d = 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        core_en = 1'b1;
        cnt_d   = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        if (core_done) begin
          rsp_cos_d = core_cos;
          rsp_err_d = 1'b0;
          state_d   = S_DELIVER;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_W'(TIMEOUT)) begin
            rsp_cos_d = '0;
            rsp_err_d = 1'b1;
            state_d   = S_DELIVER;
          end
        end
      end
      S_DELIVER: begin
        rsp_valid[tag_q] = 1'b1;
        rr_ptr_d = (tag_q == PTR_W'(N_REQ - 1)) ? '0 : tag_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Reset must win over the combinational strobes in its own cycle
    if (reset) begin
      req_ready = '0;
      rsp_valid = '0;
      core_en   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      rsp_cos_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      rsp_cos_q <= rsp_cos_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q   <= tag_d;
    angle_q <= angle_d;
  end

  cordic_unrolled_four_loop #(.W(W)) u_core (
    .clk     (clk),
    .clk_en  (core_en),
    .reset   (reset),
    .angle   (angle_q),
    .cos_out (core_cos),
    .done    (core_done)
  );

  assign rsp_cos = rsp_cos_q;
  assign rsp_err = rsp_err_q;
  assign busy    = !reset && (state_q != S_IDLE);

endmodule

// File: tb/tb_cordic_cos_arbiter.sv
// Directed bench for cordic_cos_arbiter: arbitration order, latency,
// cosine accuracy, range errors, reset abort and timeout.
module tb_cordic_cos_arbiter;

  localparam int N   = 4;
  localparam int W   = 22;
  localparam int TO  = 32;
  localparam int ONE = 32'h0010_0000;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_angle;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_cos;
  logic           rsp_err;
  logic           busy;

  int checks  = 0;
  int errors  = 0;
  int en_cnt  = 0;
  int rsp_cnt = 0;

  cordic_cos_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_angle (req_angle),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_cos   (rsp_cos),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dut.core_en) en_cnt <= en_cnt + 1;
    if (rsp_valid != '0) rsp_cnt <= rsp_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cos(input string tag, input logic [W-1:0] obs, input int exp, input int tol);
    int v, d;
    v = int'($signed(obs));
    d = v - exp;
    if (d < 0) d = -d;
    checks++;
    assert (d <= tol) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d +/-%0d", tag, v, exp, tol);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_req(input int k, input logic [W-1:0] ang);
    req_angle[k*W +: W] = ang;
    req_valid[k] = 1'b1;
  endtask

  task automatic await_grant(input string tag, input int k);
    int t;
    t = 0;
    #1;
    while (req_ready == '0 && t < 20) begin
      cyc();
      #1;
      t++;
    end
    check({tag, "_gnt"}, 32'(req_ready), 32'(1 << k));
  endtask

  task automatic await_rsp(input string tag, input int k, input int lat_exp,
                           input logic err_exp, input int cos_exp, input int tol);
    int lat;
    cyc();
    req_valid = '0;
    #1;
    lat = 1;
    while (rsp_valid == '0 && lat < 60) begin
      cyc();
      #1;
      lat++;
    end
    check({tag, "_rsp"}, 32'(rsp_valid), 32'(1 << k));
    check({tag, "_lat"}, lat, lat_exp);
    check({tag, "_err"}, 32'(rsp_err), 32'(err_exp));
    check_cos({tag, "_cos"}, rsp_cos, cos_exp, tol);
    cyc();
    #1;
    check({tag, "_strobe"}, 32'(rsp_valid), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_errhold"}, 32'(rsp_err), 32'(err_exp));
    check_cos({tag, "_hold"}, rsp_cos, cos_exp, tol);
  endtask

  initial begin
    int g, r, last, e0, r0;

    reset     = 1'b1;
    req_valid = '1;
    req_angle = '0;
    cyc();
    cyc();
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rspv", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cos", 32'(rsp_cos), 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_en", en_cnt, 0);

    // All four held valid from reset release
    reset = 1'b0;
    g = 0;
    r = 0;
    last = 0;
    for (int t = 0; t < 60; t++) begin
      #1;
      if (rsp_valid != '0) begin
        check($sformatf("rr_rsp%0d", r), 32'(rsp_valid), 32'(1 << (r % 4)));
        check_cos($sformatf("rr_cos%0d", r), rsp_cos, ONE, 16);
        r++;
      end
      if (req_ready != '0) begin
        check($sformatf("rr_gnt%0d", g), 32'(req_ready), 32'(1 << (g % 4)));
        if (g > 0) check($sformatf("rr_gap%0d", g), t - last, 9);
        last = t;
        g++;
        if (g == 5) break;
      end
      cyc();
    end
    check("rr_grants", g, 5);
    check("rr_rsps", r, 4);
    await_rsp("rr_last", 0, 8, 1'b0, ONE, 16);

    // Single request, angle 0
    e0 = en_cnt;
    set_req(0, 22'h000000);
    await_grant("a0", 0);
    await_rsp("a0", 0, 8, 1'b0, ONE, 16);
    check("a0_en", en_cnt - e0, 1);

    // pi/3 on requester 2
    set_req(2, 22'h10C152);
    await_grant("pi3", 2);
    await_rsp("pi3", 2, 8, 1'b0, 32'h080000, 16);

    // Largest in-range angle, pi/2
    set_req(3, 22'h1921FB);
    await_grant("pi2", 3);
    await_rsp("pi2", 3, 8, 1'b0, 0, 16);

    // Out-of-range angles: sign bit set, and one past pi/2
    e0 = en_cnt;
    set_req(1, 22'h200000);
    await_grant("neg", 1);
    await_rsp("neg", 1, 1, 1'b1, 0, 0);
    set_req(3, 22'h1921FC);
    await_grant("over", 3);
    await_rsp("over", 3, 1, 1'b1, 0, 0);
    check("oor_en", en_cnt - e0, 0);

    // Leave rr_ptr at 2, then abort a job with reset 3 cycles into BUSY
    set_req(1, 22'h000000);
    await_grant("pre", 1);
    await_rsp("pre", 1, 8, 1'b0, ONE, 16);
    set_req(2, 22'h10C152);
    await_grant("abort", 2);
    cyc();
    req_valid = '0;
    cyc();
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    r0 = rsp_cnt;
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    for (int t = 0; t < 12; t++) cyc();
    check("abort_norsp", rsp_cnt - r0, 0);
    req_angle = '0;
    req_valid = 4'b1001;
    await_grant("post", 0);
    await_rsp("post", 0, 8, 1'b0, ONE, 16);

    // Core done held low: timeout after TO BUSY cycles
    force dut.core_done = 1'b0;
    set_req(2, 22'h000000);
    await_grant("tmo", 2);
    await_rsp("tmo", 2, TO + 2, 1'b1, 0, 0);
    release dut.core_done;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_cos_arbiter.md
CORDIC_COS_ARBITER -- requirements
Module: cordic_cos_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter W, default 22, angle/result width; fixed-point, 20 fractional bits (1.0 = 0x100000).
REQ-003 Parameter TIMEOUT, default 32, maximum BUSY cycles before the job is aborted.
REQ-004 clk  in  1  clock; all logic on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  N_REQ  per-requester request; held until accepted.
REQ-007 req_angle  in  N_REQ*W  packed angles; requester k occupies bits [W*k+W-1 : W*k].
REQ-008 req_ready  out  N_REQ  one-hot acceptance pulse to the granted requester.
REQ-009 rsp_valid  out  N_REQ  one-hot, one-cycle result strobe to the owning requester.
REQ-010 rsp_cos  out  W  cosine result, valid while rsp_valid is non-zero.
REQ-011 rsp_err  out  1  error flag (range or timeout), qualified by rsp_valid.
REQ-012 busy  out  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, LAUNCH, BUSY, DELIVER.
REQ-014 IDLE: if any req_valid is high, grant the first requester at or after rr_ptr (wrapping); assert req_ready[k] combinationally in that cycle; latch angle and tag k.
REQ-015 IDLE to LAUNCH on grant with an in-range angle; IDLE to DELIVER with rsp_err=1 and no core launch when the angle is out of range.
REQ-016 In-range angle: bit W-1 clear and value <= 0x1921FB (pi/2); all others are out of range.
REQ-017 LAUNCH: drive core clk_en high for exactly one cycle with the latched angle; clear the timeout counter; go to BUSY.
REQ-018 BUSY: on core done, capture cos_out and go to DELIVER with rsp_err=0; else increment the counter; when it reaches TIMEOUT, go to DELIVER with rsp_err=1 and rsp_cos=0.
REQ-019 DELIVER: assert rsp_valid[tag] for exactly one cycle; set rr_ptr = (tag+1) mod N_REQ; go to IDLE.
REQ-020 Core clk_en SHALL be low in every state except LAUNCH.
REQ-021 Nominal latency SHALL be 8 cycles from the req_ready cycle to the rsp_valid cycle; throughput one job per 9 cycles.
REQ-022 Out-of-range latency SHALL be 1 cycle from req_ready to rsp_valid.
REQ-023 req_valid changes outside IDLE SHALL be ignored until the next IDLE cycle; at most one req_ready bit is high per cycle.
REQ-024 A core done seen outside BUSY SHALL be ignored.
REQ-025 rsp_cos and rsp_err SHALL hold their last values between strobes.

Reset
REQ-026 Reset SHALL force IDLE, rr_ptr=0, counter=0, req_ready=0, rsp_valid=0, rsp_cos=0, rsp_err=0, busy=0, core clk_en=0.
REQ-027 The same reset SHALL drive the core; reset during LAUNCH, BUSY or DELIVER discards the job and produces no rsp_valid.
REQ-028 Reset has priority over all other inputs in the same cycle.

Structure
REQ-029 A shared package cordic_pkg SHALL hold the state encoding, ANGLE_MAX_PI2 = 0x1921FB, ONE_Q20 = 0x100000 and the default W.
REQ-030 One sub-module SHALL be instantiated: cordic_unrolled_four_loop, the 16-iteration cosine core (clk, clk_en, reset, angle, cos_out, done).
REQ-031 Round-robin selection SHALL be coded inline; no further sub-modules.

Verification
REQ-032 Single request, req 0, angle 0 -> req_ready[0] in cycle c0, rsp_valid[0] at c0+8, rsp_cos = 0x100000 +/-16, rsp_err=0.
REQ-033 Single request, req 2, angle 0x10C152 (pi/3) -> rsp_valid[2] only, rsp_cos = 0x080000 +/-16.
REQ-034 All four requesters held valid from reset release -> grants in order 0,1,2,3,0, spaced 9 cycles apart; each rsp_valid matches its own tag.
REQ-035 Request with angle 0x200000, then one with 0x1921FC -> each gets rsp_err=1 one cycle after req_ready; core clk_en never asserted.
REQ-036 Reset pulsed 3 cycles into BUSY -> no rsp_valid, busy=0 next cycle, rr_ptr=0, next request served normally.
REQ-037 Core done forced low (stub) -> rsp_err=1 after TIMEOUT BUSY cycles, rsp_cos=0, arbiter returns to IDLE.
